// File: rtl/alu_result_sel_pipe.sv
// Registered ALU result selector.
// Picks one of NUM_SRC packed functional-unit results by sel. The less-than
// source is reduced to bit 0 and zero-extended. Zero and negative flags are
// derived from the selected data. Entries pass through a 2-entry skid buffer
// with valid/ready handshakes on both sides. Every output is driven from a
// flop or from the occupancy count, so no input reaches an output
// combinationally.
module alu_result_sel_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = 3,
    parameter int SLT_IDX = 4,
    parameter int ERR_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     zero_flag,
    output logic                     neg_flag,
    output logic                     sel_err,
    output logic [ERR_W-1:0]         err_cnt
);

    // One buffered result. The flags are stored with the data so the outputs
    // come straight from flops.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             neg;
        logic             err;
    } entry_t;

    logic [WIDTH-1:0]   src_arr [NUM_SRC];
    logic [NUM_SRC-1:0] hit;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_bad;
    entry_t             new_entry;

    logic               push;
    logic               pop;
    logic [1:0]         count_reg;
    logic [1:0]         count_next;
    entry_t             head_reg;
    entry_t             head_next;
    entry_t             tail_reg;
    entry_t             tail_next;
    logic               valid_reg;
    logic [ERR_W-1:0]   err_cnt_reg;
    logic [ERR_W-1:0]   err_cnt_next;

    // Unpack the source bus and decode the select into a one-hot hit vector.
    // When sel is out of range, no bit of hit is set.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_arr[gi] = src_bus[gi*WIDTH +: WIDTH];
        assign hit[gi]     = (sel == SEL_W'(gi));
    end

    // Source mux. The less-than source contributes only its bit 0.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (hit[k]) begin
                if (k == SLT_IDX) begin
                    sel_data = {{(WIDTH-1){1'b0}}, src_arr[k][0]};
                end else begin
                    sel_data = src_arr[k];
                end
            end
        end
        sel_bad = ~|hit;
    end

    // Build the entry to be pushed. A bad select yields data=0, which sets
    // zero and clears neg.
    always_comb begin
        new_entry.data = sel_data;
        new_entry.zero = (sel_data == '0);
        new_entry.neg  = sel_data[WIDTH-1];
        new_entry.err  = sel_bad;
    end

    assign in_ready = (count_reg != 2'd2);
    assign push     = in_valid & in_ready;
    assign pop      = valid_reg & out_ready;

    // Buffer next-state logic. The head slot always feeds the outputs. The
    // tail slot only fills while the head is stalled.
    always_comb begin
        count_next = count_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        case ({push, pop})
            2'b10: begin
                if (count_reg == 2'd0) begin
                    head_next = new_entry;
                end else begin
                    tail_next = new_entry;
                end
                count_next = count_reg + 2'd1;
            end
            2'b01: begin
                if (count_reg == 2'd2) begin
                    head_next = tail_reg;
                end
                count_next = count_reg - 2'd1;
            end
            2'b11: begin
                // Reachable only at count 1: the departing head is replaced in place.
                head_next = new_entry;
            end
            default: ;
        endcase
    end

    // Saturating count of accepted out-of-range selects.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (push && sel_bad && (err_cnt_reg != {ERR_W{1'b1}})) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end
    end

    // State registers. Reset clears everything at once, including any
    // in-flight entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= 2'd0;
            head_reg    <= '0;
            tail_reg    <= '0;
            valid_reg   <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            count_reg   <= count_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            valid_reg   <= (count_next != 2'd0);
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign out_valid = valid_reg;
    assign result    = head_reg.data;
    assign zero_flag = head_reg.zero;
    assign neg_flag  = head_reg.neg;
    assign sel_err   = head_reg.err;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Directed testbench for alu_result_sel_pipe (NUM_SRC=6, so select values 6 and 7 are bad).
module tb_alu_result_sel_pipe;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 6;
    localparam int SEL_W   = 3;
    localparam int SLT_IDX = 4;
    localparam int ERR_W   = 8;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_SRC*WIDTH-1:0] src_bus;
    logic [SEL_W-1:0]         sel;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         result;
    logic                     zero_flag;
    logic                     neg_flag;
    logic                     sel_err;
    logic [ERR_W-1:0]         err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_sel_pipe #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .SLT_IDX(SLT_IDX), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src_bus(src_bus), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag), .neg_flag(neg_flag),
        .sel_err(sel_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per delivered result.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready)
            $display("[%0t] pop result=%h zero=%0b neg=%0b sel_err=%0b err_cnt=%0d",
                     $time, result, zero_flag, neg_flag, sel_err, err_cnt);
    end

    // Advance one clock and settle 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_src();
        for (int k = 0; k < NUM_SRC; k++)
            src_bus[k*WIDTH +: WIDTH] = 32'h1000_0000 + k;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = '0;
        set_default_src();
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_err_cnt got %h want 0", err_cnt); end
        n_checks++; if ({zero_flag, neg_flag, sel_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {zero_flag, neg_flag, sel_err}); end
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1; sel = 3'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
        n_checks++; if (result !== 32'h1000_0002) begin n_fail++; $display("FAIL basic_result got %h want 10000002", result); end
        n_checks++; if ({zero_flag, neg_flag, sel_err} !== 3'b000) begin n_fail++; $display("FAIL basic_flags got %b want 000", {zero_flag, neg_flag, sel_err}); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b want 0", out_valid); end
    endtask

    task automatic test_slt_and_neg();
        out_ready = 1'b1;
        src_bus[4*WIDTH +: WIDTH] = 32'hFFFF_FFFF; sel = 3'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (result !== 32'h0000_0001) begin n_fail++; $display("FAIL slt_one got %h want 00000001", result); end
        n_checks++; if ({zero_flag, neg_flag} !== 2'b00) begin n_fail++; $display("FAIL slt_one_flags got %b want 00", {zero_flag, neg_flag}); end
        step();
        src_bus[4*WIDTH +: WIDTH] = 32'hFFFF_FFFE; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL slt_zero got %h want 0", result); end
        n_checks++; if ({zero_flag, neg_flag} !== 2'b10) begin n_fail++; $display("FAIL slt_zero_flags got %b want 10", {zero_flag, neg_flag}); end
        step();
        src_bus[3*WIDTH +: WIDTH] = 32'h8000_0000; sel = 3'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if ({result, zero_flag, neg_flag} !== {32'h8000_0000, 2'b01}) begin n_fail++; $display("FAIL neg got %h/%b%b want 80000000/01", result, zero_flag, neg_flag); end
        step();
        set_default_src();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0;
        step();
        sel = 3'd1;
        step();
        sel = 3'd2;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got %b want 0", in_ready); end
        step();
        n_checks++; if ({in_ready, out_valid} !== 2'b01) begin n_fail++; $display("FAIL bp_hold_hs got %b want 01", {in_ready, out_valid}); end
        n_checks++; if (result !== 32'h1000_0000) begin n_fail++; $display("FAIL bp_hold_result got %h want 10000000", result); end
        out_ready = 1'b1;
        step();
        n_checks++; if (result !== 32'h1000_0001) begin n_fail++; $display("FAIL bp_second got %h want 10000001", result); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_skid_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if ({out_valid, result} !== {1'b1, 32'h1000_0002}) begin n_fail++; $display("FAIL bp_third got %b/%h want 1/10000002", out_valid, result); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sel = SEL_W'(i % NUM_SRC);
            exp = (i % NUM_SRC == SLT_IDX) ? 32'h0 : 32'h1000_0000 + (i % NUM_SRC);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
            step();
            n_checks++; if ({out_valid, result} !== {1'b1, exp}) begin n_fail++; $display("FAIL b2b_result[%0d] got %b/%h want 1/%h", i, out_valid, result, exp); end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_bad_select();
        out_ready = 1'b1; in_valid = 1'b1; sel = 3'd7;
        step();
        n_checks++; if ({result, sel_err, zero_flag, neg_flag} !== {32'h0, 3'b110}) begin n_fail++; $display("FAIL bad7 got %h/%b%b%b want 0/110", result, sel_err, zero_flag, neg_flag); end
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL bad7_cnt got %0d want 1", err_cnt); end
        sel = 3'd6;
        step();
        n_checks++; if ({sel_err, err_cnt} !== {1'b1, 8'd2}) begin n_fail++; $display("FAIL bad6 got %b/%0d want 1/2", sel_err, err_cnt); end
        sel = 3'd5;
        step();
        n_checks++; if ({sel_err, result, err_cnt} !== {1'b0, 32'h1000_0005, 8'd2}) begin n_fail++; $display("FAIL good5 got %b/%h/%0d want 0/10000005/2", sel_err, result, err_cnt); end
        sel = 3'd7;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        step();
        n_checks++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL err_sat got %h want ff", err_cnt); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd1;
        step();
        sel = 3'd2;
        step();
        in_valid = 1'b0;
        n_checks++; if ({in_ready, out_valid} !== 2'b01) begin n_fail++; $display("FAIL ar_full got %b want 01", {in_ready, out_valid}); end
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, result, err_cnt} !== {1'b0, 32'h0, 8'h0}) begin n_fail++; $display("FAIL ar_clear got %b/%h/%h want 0/0/0", out_valid, result, err_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready got %b want 1", in_ready); end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL ar_stale[%0d] got %b want 01", i, {out_valid, in_ready}); end
        end
        sel = 3'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if ({out_valid, result} !== {1'b1, 32'h1000_0003}) begin n_fail++; $display("FAIL ar_after got %b/%h want 1/10000003", out_valid, result); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slt_and_neg();
        test_backpressure();
        test_back_to_back();
        test_bad_select();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
